// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with a small circular buffer.
// It holds up to DEPTH in-flight instructions. Each entry is {payload, pc, exc, fault_addr}.
// Outputs are zeroed (bubble) whenever no entry is presented.
// After an instruction that carries an exception is accepted, no further pushes
// are accepted until it leaves or is flushed. This keeps exceptions precise.
module pipe_stage_reg #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       flush,
  input  logic                       stall,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_data,
  input  logic [ADDR_W-1:0]          in_pc,
  input  logic                       in_exc,
  input  logic [ADDR_W-1:0]          in_fault_addr,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic [ADDR_W-1:0]          out_pc,
  output logic                       out_exc,
  output logic [ADDR_W-1:0]          out_fault_addr,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       exc_pending
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // Entry storage
  logic [DATA_W-1:0] r_mem_data  [DEPTH];
  logic [ADDR_W-1:0] r_mem_pc    [DEPTH];
  logic              r_mem_exc   [DEPTH];
  logic [ADDR_W-1:0] r_mem_fault [DEPTH];

  // Control state
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_exc_pending;

  // Next-state values and handshake strobes
  logic [PTR_W-1:0] w_wr_ptr_nxt;
  logic [PTR_W-1:0] w_rd_ptr_nxt;
  logic [CNT_W-1:0] w_count_nxt;
  logic             w_exc_pending_nxt;
  logic             w_push;
  logic             w_pop;
  logic             w_head_exc;

  // Handshake outputs, combinational from current state and the stage controls
  always_comb begin
    in_ready  = !stall && !flush && (r_count < FULL_CNT) && !r_exc_pending;
    out_valid = (r_count != '0) && !stall && !flush;
    w_push    = in_valid && in_ready;
    w_pop     = out_valid && out_ready;
  end

  // Head entry fields; a bubble drives zeros so stale storage never leaks out
  always_comb begin
    w_head_exc     = r_mem_exc[r_rd_ptr];
    out_data       = '0;
    out_pc         = '0;
    out_exc        = 1'b0;
    out_fault_addr = '0;
    if (out_valid) begin
      out_data       = r_mem_data[r_rd_ptr];
      out_pc         = r_mem_pc[r_rd_ptr];
      out_exc        = r_mem_exc[r_rd_ptr];
      out_fault_addr = r_mem_fault[r_rd_ptr];
    end
  end

  // Next pointers, occupancy and exception flag; flush overrides everything
  always_comb begin
    // NOTE: every output of this block is assigned a default first, so no path leaves it unassigned and no latch is inferred.
    w_wr_ptr_nxt      = r_wr_ptr;
    w_rd_ptr_nxt      = r_rd_ptr;
    w_count_nxt       = r_count;
    w_exc_pending_nxt = r_exc_pending;
    if (flush) begin
      w_wr_ptr_nxt      = '0;
      w_rd_ptr_nxt      = '0;
      w_count_nxt       = '0;
      w_exc_pending_nxt = 1'b0;
    end else begin
      // DEPTH is a power of two, so the pointers wrap on natural overflow
      if (w_push) w_wr_ptr_nxt = r_wr_ptr + PTR_W'(1);
      if (w_pop)  w_rd_ptr_nxt = r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   w_count_nxt = r_count + CNT_W'(1);
        2'b01:   w_count_nxt = r_count - CNT_W'(1);
        default: w_count_nxt = r_count;
      endcase
      // The exception entry is always the youngest held entry, so popping it empties the flag
      if (w_pop && w_head_exc) w_exc_pending_nxt = 1'b0;
      if (w_push && in_exc)    w_exc_pending_nxt = 1'b1;
    end
  end

  // Control registers with asynchronous clear
  always_ff @(posedge clock or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset_n) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_exc_pending <= 1'b0;
    end else begin
      r_wr_ptr      <= w_wr_ptr_nxt;
      r_rd_ptr      <= w_rd_ptr_nxt;
      r_count       <= w_count_nxt;
      r_exc_pending <= w_exc_pending_nxt;
    end
  end

  // Entry write on accepted push
  always_ff @(posedge clock) begin
    // NOTE: storage has no reset; the bubble muxing guarantees it is invisible until written.
    if (w_push) begin
      r_mem_data[r_wr_ptr]  <= in_data;
      r_mem_pc[r_wr_ptr]    <= in_pc;
      r_mem_exc[r_wr_ptr]   <= in_exc;
      r_mem_fault[r_wr_ptr] <= in_fault_addr;
    end
  end

  assign count       = r_count;
  assign exc_pending = r_exc_pending;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg with default parameters (DEPTH=2).
// It runs a directed vector table, hand-written streaming and async-reset sequences,
// and randomized traffic checked against a queue-based reference model.
module tb_pipe_stage_reg;

  localparam int DEPTH = 2;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        flush, stall, in_valid, in_ready, in_exc;
  logic        out_valid, out_ready, out_exc, exc_pending;
  logic [31:0] in_data, in_pc, in_fault_addr;
  logic [31:0] out_data, out_pc, out_fault_addr;
  logic [1:0]  count;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clock = ~clock;

  pipe_stage_reg #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .flush          (flush),
    .stall          (stall),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .in_pc          (in_pc),
    .in_exc         (in_exc),
    .in_fault_addr  (in_fault_addr),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_pc         (out_pc),
    .out_exc        (out_exc),
    .out_fault_addr (out_fault_addr),
    .count          (count),
    .exc_pending    (exc_pending)
  );

  // Reference model: an ordered list of held entries
  typedef struct {
    logic [31:0] d;
    logic [31:0] pc;
    logic        e;
    logic [31:0] fa;
  } ent_t;
  ent_t q[$];

  // Directed vector: inputs for one cycle plus outputs expected in that cycle
  typedef struct {
    logic        fl, st, iv;
    logic [31:0] pc;
    logic        ex;
    logic [31:0] fa;
    logic        ordy;
    logic        e_rdy, e_vld;
    logic [1:0]  e_cnt;
    logic [31:0] e_pc;
    logic        e_excp;
    logic [31:0] e_fa;
  } vec_t;
  vec_t tbl[20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic bit m_exc();
    foreach (q[i]) if (q[i].e) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_rdy();
    return !stall && !flush && (q.size() < DEPTH) && !m_exc();
  endfunction

  function automatic bit m_vld();
    return (q.size() != 0) && !stall && !flush;
  endfunction

  // Apply one cycle of inputs after the falling edge, then let outputs settle
  task automatic drive(input logic fl, input logic st, input logic iv, input logic [31:0] d,
                       input logic [31:0] pc, input logic ex, input logic [31:0] fa,
                       input logic ordy);
    @(negedge clock);
    flush = fl; stall = st; in_valid = iv; in_data = d;
    in_pc = pc; in_exc = ex; in_fault_addr = fa; out_ready = ordy;
    #1;
  endtask

  // Update the model from the handshake rules, then take the rising edge
  task automatic advance();
    bit   rdy, vld;
    ent_t e;
    rdy = m_rdy();
    vld = m_vld();
    if (flush) q.delete();
    else begin
      if (vld && out_ready) void'(q.pop_front());
      if (in_valid && rdy) begin
        e.d = in_data; e.pc = in_pc; e.e = in_exc; e.fa = in_fault_addr;
        q.push_back(e);
      end
    end
    @(posedge clock);
  endtask

  task automatic model_check();
    bit vld;
    vld = m_vld();
    check("in_ready",    in_ready,    m_rdy());
    check("out_valid",   out_valid,   vld);
    check("count",       count,       q.size());
    check("exc_pending", exc_pending, m_exc());
    check("out_data",    out_data,    vld ? q[0].d  : 32'h0);
    check("out_pc",      out_pc,      vld ? q[0].pc : 32'h0);
    check("out_exc",     out_exc,     vld ? q[0].e  : 1'b0);
    check("out_fa",      out_fault_addr, vld ? q[0].fa : 32'h0);
  endtask

  function automatic vec_t mk(logic fl, logic st, logic iv, logic [31:0] pc, logic ex,
                              logic [31:0] fa, logic ordy, logic e_rdy, logic e_vld,
                              logic [1:0] e_cnt, logic [31:0] e_pc, logic e_excp,
                              logic [31:0] e_fa);
    vec_t v;
    v.fl = fl; v.st = st; v.iv = iv; v.pc = pc; v.ex = ex; v.fa = fa; v.ordy = ordy;
    v.e_rdy = e_rdy; v.e_vld = e_vld; v.e_cnt = e_cnt; v.e_pc = e_pc;
    v.e_excp = e_excp; v.e_fa = e_fa;
    return v;
  endfunction

  initial begin
    logic [31:0] exp_d;

    //            fl st iv pc         ex fa            ordy rdy vld cnt out_pc     excp out_fa
    // Fill to full, full blocks push even while popping, drain in order
    tbl[0]  = mk(0, 0, 1, 32'h100, 0, 32'h0,        0,   1,  0,  0, 32'h0,   0, 32'h0);
    tbl[1]  = mk(0, 0, 1, 32'h104, 0, 32'h0,        0,   1,  1,  1, 32'h100, 0, 32'h0);
    tbl[2]  = mk(0, 0, 0, 32'h0,   0, 32'h0,        0,   0,  1,  2, 32'h100, 0, 32'h0);
    tbl[3]  = mk(0, 0, 1, 32'h108, 0, 32'h0,        1,   0,  1,  2, 32'h100, 0, 32'h0);
    tbl[4]  = mk(0, 0, 0, 32'h0,   0, 32'h0,        1,   1,  1,  1, 32'h104, 0, 32'h0);
    tbl[5]  = mk(0, 0, 0, 32'h0,   0, 32'h0,        0,   1,  0,  0, 32'h0,   0, 32'h0);
    // Exception entry blocks the follower until popped
    tbl[6]  = mk(0, 0, 1, 32'h200, 1, 32'hDEAD0000, 0,   1,  0,  0, 32'h0,   0, 32'h0);
    tbl[7]  = mk(0, 0, 1, 32'h204, 0, 32'h0,        0,   0,  1,  1, 32'h200, 1, 32'hDEAD0000);
    tbl[8]  = mk(0, 0, 1, 32'h204, 0, 32'h0,        1,   0,  1,  1, 32'h200, 1, 32'hDEAD0000);
    tbl[9]  = mk(0, 0, 1, 32'h204, 0, 32'h0,        0,   1,  0,  0, 32'h0,   0, 32'h0);
    tbl[10] = mk(0, 0, 1, 32'h208, 0, 32'h0,        0,   1,  1,  1, 32'h204, 0, 32'h0);
    // Flush with a concurrent offer
    tbl[11] = mk(1, 0, 1, 32'h20C, 0, 32'h0,        0,   0,  0,  2, 32'h0,   0, 32'h0);
    tbl[12] = mk(0, 0, 0, 32'h0,   0, 32'h0,        0,   1,  0,  0, 32'h0,   0, 32'h0);
    // Stall freezes a one-entry buffer
    tbl[13] = mk(0, 0, 1, 32'h300, 0, 32'h0,        0,   1,  0,  0, 32'h0,   0, 32'h0);
    tbl[14] = mk(0, 1, 1, 32'h304, 0, 32'h0,        1,   0,  0,  1, 32'h0,   0, 32'h0);
    tbl[15] = mk(0, 1, 1, 32'h304, 0, 32'h0,        1,   0,  0,  1, 32'h0,   0, 32'h0);
    tbl[16] = mk(0, 1, 1, 32'h304, 0, 32'h0,        1,   0,  0,  1, 32'h0,   0, 32'h0);
    tbl[17] = mk(0, 0, 0, 32'h0,   0, 32'h0,        0,   1,  1,  1, 32'h300, 0, 32'h0);
    tbl[18] = mk(0, 0, 0, 32'h0,   0, 32'h0,        1,   1,  1,  1, 32'h300, 0, 32'h0);
    tbl[19] = mk(0, 0, 0, 32'h0,   0, 32'h0,        0,   1,  0,  0, 32'h0,   0, 32'h0);

    reset_n = 1'b0;
    flush = 0; stall = 0; in_valid = 0; in_data = '0; in_pc = '0;
    in_exc = 0; in_fault_addr = '0; out_ready = 0;
    #3;
    check("rst.count",       count,       2'd0);
    check("rst.out_valid",   out_valid,   1'b0);
    check("rst.out_pc",      out_pc,      32'h0);
    check("rst.exc_pending", exc_pending, 1'b0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;

    // Directed table
    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].fl, tbl[i].st, tbl[i].iv, ~tbl[i].pc, tbl[i].pc, tbl[i].ex,
            tbl[i].fa, tbl[i].ordy);
      exp_d = tbl[i].e_vld ? ~tbl[i].e_pc : 32'h0;
      check("tbl.in_ready",    in_ready,       tbl[i].e_rdy);
      check("tbl.out_valid",   out_valid,      tbl[i].e_vld);
      check("tbl.count",       count,          tbl[i].e_cnt);
      check("tbl.out_pc",      out_pc,         tbl[i].e_pc);
      check("tbl.exc_pending", exc_pending,    tbl[i].e_excp);
      check("tbl.out_fa",      out_fault_addr, tbl[i].e_fa);
      check("tbl.out_data",    out_data,       exp_d);
      advance();
    end

    // Streaming: one entry per cycle across several pointer wraps
    for (int i = 0; i <= 10; i++) begin
      drive(0, 0, i < 10, ~(32'(i) * 32'd4), 32'(i) * 32'd4, 0, 32'h0, 1);
      check("strm.in_ready",  in_ready,  1'b1);
      check("strm.count",     count,     (i == 0) ? 2'd0 : 2'd1);
      check("strm.out_valid", out_valid, i != 0);
      if (i != 0) check("strm.out_pc", out_pc, 32'(i - 1) * 32'd4);
      advance();
    end

    // Asynchronous reset with two entries held
    drive(0, 0, 1, 32'h1, 32'h400, 0, 32'h0, 0); advance();
    drive(0, 0, 1, 32'h2, 32'h404, 0, 32'h0, 0); advance();
    drive(0, 0, 0, 32'h0, 32'h0,   0, 32'h0, 0);
    check("arst.pre_count", count, 2'd2);
    #2 reset_n = 1'b0;
    #1;
    check("arst.count",       count,       2'd0);
    check("arst.out_valid",   out_valid,   1'b0);
    check("arst.out_pc",      out_pc,      32'h0);
    check("arst.exc_pending", exc_pending, 1'b0);
    q.delete();
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1; in_valid = 1'b1; in_pc = 32'h500; in_data = 32'h5A5A;
    #1;
    check("arst.in_ready", in_ready, 1'b1);
    advance();
    drive(0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 0);
    check("arst.post_count", count,    2'd1);
    check("arst.post_pc",    out_pc,   32'h500);
    check("arst.post_data",  out_data, 32'h5A5A);
    advance();

    // Randomized traffic against the reference model
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(19) == 0, $urandom_range(7) == 0, $urandom_range(1) == 1,
            $urandom, $urandom, $urandom_range(7) == 0, $urandom, $urandom_range(3) != 0);
      model_check();
      advance();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Watchdog so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
